// File: rtl/usb_pkg.sv
// Shared USB definitions: PID nibbles, handshake-type encoding and the
// transmit scheduler state encoding.
package usb_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [1:0] {
    HS_ACK   = 2'b00,
    HS_NAK   = 2'b01,
    HS_STALL = 2'b10,
    HS_RSVD  = 2'b11
  } hs_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HS_SEND,
    ST_HS_WAIT,
    ST_DATA_SEND,
    ST_DATA_WAIT,
    ST_AWAIT_HS
  } state_type;

  // Reserved handshake type is sent as NAK.
  function automatic logic [3:0] hs_pid(input logic [1:0] t);
    logic [3:0] pid;
    case (hs_type_e'(t))
      HS_ACK:   pid = PID_ACK;
      HS_STALL: pid = PID_STALL;
      default:  pid = PID_NAK;
    endcase
    return pid;
  endfunction

endpackage

// File: rtl/usb_timeout_counter.sv
// Handshake timeout counter: counts while enabled, holds at the terminal
// value, and flags expiry while count == TIMEOUT_CYCLES-1.
module usb_timeout_counter #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Shares the USB packet transmitter between handshake and bulk-IN data
// requesters; runs the data handshake wait, retry and toggle bookkeeping.
module usb_tx_scheduler
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  output logic       hs_gnt,
  input  logic       data_req,
  output logic       data_gnt,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  input  logic       tx_complete,
  output logic       rx_en,
  input  logic       rcvd_hs_valid,
  input  logic [3:0] rcvd_hs_pid,
  output logic       data_done,
  output logic       data_fail,
  output logic       data_toggle,
  input  logic       toggle_clr,
  output logic       busy
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  state_type       state_q, state_d;
  logic [3:0]      tx_pid_q, tx_pid_d;
  logic [RW-1:0]   retry_q, retry_d, retry_inc;
  logic            toggle_q, toggle_d;
  logic            tx_start_q, tx_start_d;
  logic            hs_gnt_q, hs_gnt_d;
  logic            data_gnt_q, data_gnt_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic            rx_en_q, rx_en_d;
  logic            busy_q, busy_d;
  logic            start_data, bump_retry;
  logic            cnt_clear, cnt_enable, expired;

  assign retry_inc  = retry_q + 1'b1;
  assign cnt_clear  = (state_q == ST_DATA_WAIT) && tx_complete;
  assign cnt_enable = (state_q == ST_AWAIT_HS);

  usb_timeout_counter #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(expired)
  );

  // Outputs are computed from the next state and registered with it, so
  // every output is a flop and no input reaches an output combinationally.
  always_comb begin
    state_d    = state_q;
    tx_pid_d   = tx_pid_q;
    retry_d    = retry_q;
    toggle_d   = toggle_q;
    tx_start_d = 1'b0;
    hs_gnt_d   = 1'b0;
    data_gnt_d = 1'b0;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    start_data = 1'b0;
    bump_retry = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hs_req) begin
          state_d    = ST_HS_SEND;
          tx_pid_d   = hs_pid(hs_type);
          tx_start_d = 1'b1;
          hs_gnt_d   = 1'b1;
        end else if (data_req) begin
          start_data = 1'b1;
        end
      end
      ST_HS_SEND:   state_d = ST_HS_WAIT;
      ST_HS_WAIT:   if (tx_complete) state_d = ST_IDLE;
      ST_DATA_SEND: state_d = ST_DATA_WAIT;
      ST_DATA_WAIT: if (tx_complete) state_d = ST_AWAIT_HS;
      ST_AWAIT_HS: begin
        if (rcvd_hs_valid) begin
          case (rcvd_hs_pid)
            PID_ACK: begin
              toggle_d = ~toggle_q;
              done_d   = 1'b1;
              retry_d  = '0;
              state_d  = ST_IDLE;
            end
            PID_NAK:   start_data = 1'b1;
            PID_STALL: begin
              fail_d  = 1'b1;
              retry_d = '0;
              state_d = ST_IDLE;
            end
            default:   bump_retry = 1'b1;
          endcase
        end else if (expired) begin
          bump_retry = 1'b1;
        end
        if (bump_retry) begin
          if (retry_inc == RW'(MAX_RETRY)) begin
            fail_d  = 1'b1;
            retry_d = '0;
            state_d = ST_IDLE;
          end else begin
            retry_d    = retry_inc;
            start_data = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (toggle_clr) toggle_d = 1'b0;

    if (start_data) begin
      state_d    = ST_DATA_SEND;
      tx_start_d = 1'b1;
      data_gnt_d = 1'b1;
      tx_pid_d   = toggle_d ? PID_DATA1 : PID_DATA0;
    end

    if (state_d == ST_IDLE) tx_pid_d = '0;

    rx_en_d = (state_d == ST_AWAIT_HS);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_pid_q   <= '0;
      retry_q    <= '0;
      toggle_q   <= 1'b0;
      tx_start_q <= 1'b0;
      hs_gnt_q   <= 1'b0;
      data_gnt_q <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      rx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_pid_q   <= tx_pid_d;
      retry_q    <= retry_d;
      toggle_q   <= toggle_d;
      tx_start_q <= tx_start_d;
      hs_gnt_q   <= hs_gnt_d;
      data_gnt_q <= data_gnt_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      rx_en_q    <= rx_en_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_pid      = tx_pid_q;
  assign hs_gnt      = hs_gnt_q;
  assign data_gnt    = data_gnt_q;
  assign data_done   = done_q;
  assign data_fail   = fail_q;
  assign data_toggle = toggle_q;
  assign rx_en       = rx_en_q;
  assign busy        = busy_q;

endmodule
